// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: decode hazard query, ALU/MEM writeback handshakes and the
// register_file write port, with the observable pending-count.
interface regfile_wb_scheduler_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_dest_5;
   logic [ADDR_W-1:0] rd_s1_addr_5;
   logic [ADDR_W-1:0] rd_s2_addr_5;
   logic              stall;

   logic              alu_valid;
   logic [ADDR_W-1:0] alu_dest_5;
   logic [DATA_W-1:0] alu_data_32;
   logic              alu_ready;

   logic              mem_valid;
   logic [ADDR_W-1:0] mem_dest_5;
   logic [DATA_W-1:0] mem_data_32;
   logic              mem_ready;

   logic              rf_w_en;
   logic [ADDR_W-1:0] rf_w_address_d_5;
   logic [DATA_W-1:0] rf_w_data_dval_32;
   logic [ADDR_W:0]   pending_count;

   // Pipeline side: decode plus the execute/memory writeback requesters.
   modport master (
      output issue_valid, issue_dest_5, rd_s1_addr_5, rd_s2_addr_5,
      output alu_valid, alu_dest_5, alu_data_32,
      output mem_valid, mem_dest_5, mem_data_32,
      input  stall, alu_ready, mem_ready,
      input  rf_w_en, rf_w_address_d_5, rf_w_data_dval_32, pending_count
   );

   modport slave (
      input  issue_valid, issue_dest_5, rd_s1_addr_5, rd_s2_addr_5,
      input  alu_valid, alu_dest_5, alu_data_32,
      input  mem_valid, mem_dest_5, mem_data_32,
      output stall, alu_ready, mem_ready,
      output rf_w_en, rf_w_address_d_5, rf_w_data_dval_32, pending_count
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU/MEM writebacks onto the single register_file write port and tracks
// which registers still have a write outstanding so decode can stall on RAW/WAW hazards.
module regfile_wb_scheduler #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter bit          FIRST_PRIO = 1'b0
) (
   input logic                    clock,
   input logic                    reset_n,
   regfile_wb_scheduler_if.slave  wb
);

   localparam int unsigned NumRegs = 2 ** ADDR_W;
   localparam int unsigned CntW    = ADDR_W + 1;

   typedef enum logic [0:0] {
      GrantAlu = 1'b0,
      GrantMem = 1'b1
   } grant_e;

   grant_e              last_grant_q, last_grant_d;
   logic [NumRegs-1:0]  pending_q, pending_d;
   logic                rf_w_en_q, rf_w_en_d;
   logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0]   rf_data_q, rf_data_d;
   logic [CntW-1:0]     count_q, count_d;

   logic                collision;
   logic                grant;
   logic                alu_ready;
   logic                mem_ready;
   logic                issue_accept;
   logic [ADDR_W-1:0]   grant_dest;
   logic [DATA_W-1:0]   grant_data;

   // Hazard detection against the current scoreboard.
   always_comb begin
      wb.stall = pending_q[wb.rd_s1_addr_5]
               | pending_q[wb.rd_s2_addr_5]
               | (wb.issue_valid & pending_q[wb.issue_dest_5]);
      issue_accept = wb.issue_valid & ~wb.stall;
   end

   // Round-robin only matters on a collision; a lone requester is always granted.
   always_comb begin
      collision  = wb.alu_valid & wb.mem_valid;
      alu_ready  = wb.alu_valid & (~wb.mem_valid | (last_grant_q == GrantMem));
      mem_ready  = wb.mem_valid & ~alu_ready;
      grant      = alu_ready | mem_ready;
      grant_dest = alu_ready ? wb.alu_dest_5  : wb.mem_dest_5;
      grant_data = alu_ready ? wb.alu_data_32 : wb.mem_data_32;
   end

   assign wb.alu_ready = alu_ready;
   assign wb.mem_ready = mem_ready;

   always_comb begin
      last_grant_d = last_grant_q;
      if (collision) begin
         last_grant_d = alu_ready ? GrantAlu : GrantMem;
      end
   end

   // Register 0 is consumed but never written or tracked.
   always_comb begin
      rf_w_en_d = grant & (grant_dest != '0);
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (grant) begin
         rf_addr_d = grant_dest;
         rf_data_d = grant_data;
      end
   end

   // Clear first, then set, so a same-edge set leaves the register pending.
   always_comb begin
      pending_d = pending_q;
      if (rf_w_en_q) begin
         pending_d[rf_addr_q] = 1'b0;
      end
      if (issue_accept && (wb.issue_dest_5 != '0)) begin
         pending_d[wb.issue_dest_5] = 1'b1;
      end
      pending_d[0] = 1'b0;

      count_d = '0;
      for (int unsigned i = 1; i < NumRegs; i++) begin
         count_d = count_d + CntW'(pending_d[i]);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_q    <= '0;
         count_q      <= '0;
         rf_w_en_q    <= 1'b0;
         rf_addr_q    <= '0;
         rf_data_q    <= '0;
         last_grant_q <= grant_e'(~FIRST_PRIO);
      end else begin
         pending_q    <= pending_d;
         count_q      <= count_d;
         rf_w_en_q    <= rf_w_en_d;
         rf_addr_q    <= rf_addr_d;
         rf_data_q    <= rf_data_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign wb.rf_w_en           = rf_w_en_q;
   assign wb.rf_w_address_d_5  = rf_addr_q;
   assign wb.rf_w_data_dval_32 = rf_data_q;
   assign wb.pending_count     = count_q;

`ifndef SYNTHESIS
   a_one_grant : assert property (@(posedge clock) disable iff (!reset_n)
      !(alu_ready && mem_ready));
   a_r0_clear : assert property (@(posedge clock) disable iff (!reset_n)
      !pending_q[0]);
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized and directed bench for regfile_wb_scheduler against a cycle-level scoreboard
// model, with a behavioural register_file fed from the scheduler's write port.
module tb_regfile_wb_scheduler;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 32;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic rf_clr  = 1'b1;

   always #5 clock = ~clock;

   regfile_wb_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW), .FIRST_PRIO(1'b0)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .wb      (bus)
   );

   // Behavioural register_file driven by the DUT write port.
   logic [DW-1:0] rf_t [NR];
   always @(posedge clock) begin
      if (rf_clr) begin
         for (int i = 0; i < NR; i++) rf_t[i] <= '0;
      end else if (bus.rf_w_en) begin
         rf_t[bus.rf_w_address_d_5] <= bus.rf_w_data_dval_32;
      end
   end

   // Reference model state.
   bit            pend [NR];
   logic [DW-1:0] rf_m [NR];
   bit            m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   int            last_m;

   int n_checks = 0;
   int n_errors = 0;

   logic s_stall, s_ar, s_mr, s_wen;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int pop_m();
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(pend[i]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      last_m  = 1;
   endtask

   task automatic drive_idle();
      bus.issue_valid  = 1'b0;
      bus.issue_dest_5 = '0;
      bus.rd_s1_addr_5 = '0;
      bus.rd_s2_addr_5 = '0;
      bus.alu_valid    = 1'b0;
      bus.alu_dest_5   = '0;
      bus.alu_data_32  = '0;
      bus.mem_valid    = 1'b0;
      bus.mem_dest_5   = '0;
      bus.mem_data_32  = '0;
   endtask

   // One clock cycle: drive at negedge, check just after, advance the model at posedge.
   task automatic step(input bit iv, input logic [AW-1:0] idest,
                       input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                       input bit av, input logic [AW-1:0] ad, input logic [DW-1:0] ax,
                       input bit mv, input logic [AW-1:0] md, input logic [DW-1:0] mx,
                       output bit ag, output bit mg);
      bit st, acc;
      @(negedge clock);
      bus.issue_valid  = iv;
      bus.issue_dest_5 = idest;
      bus.rd_s1_addr_5 = s1;
      bus.rd_s2_addr_5 = s2;
      bus.alu_valid    = av;
      bus.alu_dest_5   = ad;
      bus.alu_data_32  = ax;
      bus.mem_valid    = mv;
      bus.mem_dest_5   = md;
      bus.mem_data_32  = mx;
      #1;
      st  = pend[s1] | pend[s2] | (iv & pend[idest]);
      acc = iv & !st;
      if (av && mv) begin
         ag = (last_m == 1);
         mg = !ag;
      end else begin
         ag = av;
         mg = mv;
      end
      s_stall = bus.stall;
      s_ar    = bus.alu_ready;
      s_mr    = bus.mem_ready;
      s_wen   = bus.rf_w_en;
      check_eq("stall", bus.stall, st);
      check_eq("alu_ready", bus.alu_ready, ag);
      check_eq("mem_ready", bus.mem_ready, mg);
      check_eq("both_ready", bus.alu_ready & bus.mem_ready, 1'b0);
      check_eq("rf_w_en", bus.rf_w_en, m_wen);
      if (m_wen) begin
         check_eq("rf_w_addr", bus.rf_w_address_d_5, m_waddr);
         check_eq("rf_w_data", bus.rf_w_data_dval_32, m_wdata);
      end
      check_eq("pending_count", bus.pending_count, pop_m());
      check_eq("rf_read_s1", rf_t[s1], rf_m[s1]);
      @(posedge clock);
      if (m_wen) begin
         rf_m[m_waddr] = m_wdata;
         pend[m_waddr] = 1'b0;
      end
      if (acc && idest != 0) pend[idest] = 1'b1;
      if (ag || mg) begin
         m_waddr = ag ? ad : md;
         m_wdata = ag ? ax : mx;
         m_wen   = (m_waddr != 0);
      end else begin
         m_wen = 1'b0;
      end
      if (av && mv) last_m = ag ? 0 : 1;
   endtask

   task automatic idle_step();
      bit ag, mg;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
   endtask

   initial begin
      bit ag, mg;
      bit a_v, m_v;
      logic [AW-1:0] a_d, m_d;
      logic [DW-1:0] a_x, m_x;

      for (int i = 0; i < NR; i++) rf_m[i] = '0;
      model_reset();
      drive_idle();
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      check_eq("reset_wen", bus.rf_w_en, 1'b0);
      check_eq("reset_addr", bus.rf_w_address_d_5, 5'd0);
      check_eq("reset_data", bus.rf_w_data_dval_32, 32'd0);
      check_eq("reset_count", bus.pending_count, 6'd0);
      check_eq("reset_stall", bus.stall, 1'b0);
      rf_clr  = 1'b0;
      reset_n = 1'b1;

      // T1: reset while a write to r5 is in flight.
      step(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      step(0, 0, 0, 0, 1, 5, 32'hAA, 0, 0, 0, ag, mg);
      #2;
      check_eq("t1_wen_before", bus.rf_w_en, 1'b1);
      reset_n = 1'b0;
      #1;
      check_eq("t1_wen_reset", bus.rf_w_en, 1'b0);
      check_eq("t1_count_reset", bus.pending_count, 6'd0);
      model_reset();
      drive_idle();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      check_eq("t1_r5_kept", rf_t[5], 32'h0);

      // T3: sustained collision right after reset alternates ALU, MEM, ALU, MEM.
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 10, DW'(i), 1, 11, DW'(100 + i), ag, mg);
         check_eq("t3_alu_grant", s_ar, (i % 2) == 0);
         check_eq("t3_mem_grant", s_mr, (i % 2) == 1);
      end
      idle_step();

      // T2: RAW on r7 resolved by an ALU write.
      step(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      step(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      check_eq("t2_stall", s_stall, 1'b1);
      step(0, 0, 7, 0, 1, 7, 32'h1234, 0, 0, 0, ag, mg);
      step(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      check_eq("t2_stall_wen", s_stall, 1'b1);
      step(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      check_eq("t2_stall_drop", s_stall, 1'b0);
      check_eq("t2_r7", rf_t[7], 32'h1234);

      // T4: register 0 is never pending and never written.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      check_eq("t4_stall", s_stall, 1'b0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD, ag, mg);
      check_eq("t4_mem_ready", s_mr, 1'b1);
      idle_step();
      check_eq("t4_no_wen", s_wen, 1'b0);

      // T5: new issue to r9 in the cycle its write is on the port.
      step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      step(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, ag, mg);
      step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      idle_step();

      // T6: WAW on r3 holds the issue until the write commits.
      step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      check_eq("t6_stall", s_stall, 1'b1);
      step(1, 3, 0, 0, 0, 0, 0, 1, 3, 32'h33, ag, mg);
      step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      check_eq("t6_stall_wen", s_stall, 1'b1);
      step(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, ag, mg);
      check_eq("t6_accept", s_stall, 1'b0);
      idle_step();

      // Randomized traffic; requesters hold their request until granted.
      a_v = 0;
      m_v = 0;
      a_d = '0;
      m_d = '0;
      a_x = '0;
      m_x = '0;
      for (int c = 0; c < 800; c++) begin
         if (!a_v && $urandom_range(0, 2) == 0) begin
            a_v = 1;
            a_d = AW'($urandom_range(0, 7));
            a_x = $urandom;
         end
         if (!m_v && $urandom_range(0, 2) == 0) begin
            m_v = 1;
            m_d = AW'($urandom_range(0, 7));
            m_x = $urandom;
         end
         step(bit'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              a_v, a_d, a_x, m_v, m_d, m_x, ag, mg);
         if (ag) a_v = 0;
         if (mg) m_v = 0;
      end

      drive_idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
